// File: rtl/video_dma.sv
// OAM DMA and CGB HDMA engine sharing one byte-slot sequencer on the source bus.
// HDMA wins each slot boundary; an OAM slot in flight always finishes first.
module video_dma #(
   parameter int OAM_BYTES       = 160,
   parameter int CYCLES_PER_BYTE = 4,
   parameter int HDMA_BLOCK      = 16,
   parameter int CGB             = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_sel_reg,
   input  logic [7:0]  cpu_addr,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_di,
   output logic [7:0]  cpu_do,
   input  logic        lcd_on,
   input  logic        hblank_start,
   output logic        cpu_stall,
   output logic        src_rd,
   output logic [15:0] src_addr,
   input  logic [7:0]  src_data,
   output logic        oam_dma_active,
   output logic        oam_wr,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_di,
   output logic        vram_wr,
   output logic [12:0] vram_addr,
   output logic [7:0]  vram_di
);
   localparam int          CW       = $clog2(CYCLES_PER_BYTE);
   localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_BYTE - 1);
   localparam logic [7:0]  OAM_LAST = 8'(OAM_BYTES - 1);
   localparam logic [15:0] BLK_LAST = 16'(HDMA_BLOCK - 1);
   localparam bit          HAS_HDMA = (CGB != 0);

   typedef enum logic [1:0] {IDLE, GDMA, HWAIT, HBLOCK} hstate_e;

   hstate_e        state_q, state_d;
   logic           busy_q, busy_d, owner_q, owner_d, hwr_q;
   logic [CW-1:0]  cyc_q, cyc_d;
   logic           oam_act_q, oam_act_d;
   logic [7:0]     page_q, page_d, idx_q, idx_d;
   logic [15:0]    hsrc_q, hsrc_d, bcnt_q, bcnt_d;
   logic [12:0]    dst_q, dst_d;
   logic [7:0]     blocks_q, blocks_d, blk_m1;
   logic           cancelled_q, cancelled_d, cancel_pend_q, cancel_pend_d;
   logic           strobe, wr46, wr_h, oam_restart, oam_wr_c, vram_wr_c, want_h;

   always_comb begin
      state_d       = state_q;
      busy_d        = busy_q;
      owner_d       = owner_q;
      cyc_d         = cyc_q;
      oam_act_d     = oam_act_q;
      page_d        = page_q;
      idx_d         = idx_q;
      hsrc_d        = hsrc_q;
      dst_d         = dst_q;
      bcnt_d        = bcnt_q;
      blocks_d      = blocks_q;
      cancelled_d   = cancelled_q;
      cancel_pend_d = cancel_pend_q;

      strobe      = busy_q && (cyc_q == CYC_LAST) && !reset;
      wr46        = cpu_sel_reg && cpu_wr && (cpu_addr == 8'h46);
      wr_h        = cpu_sel_reg && cpu_wr && HAS_HDMA;
      // A $46 rewrite drops the OAM slot in flight and restarts from byte 0.
      oam_restart = wr46 && busy_q && !owner_q;
      oam_wr_c    = strobe && !owner_q && !oam_restart;
      vram_wr_c   = strobe && owner_q;

      if (busy_q) cyc_d = cyc_q + 1'b1;

      if (oam_wr_c) begin
         idx_d = idx_q + 8'd1;
         if (idx_q == OAM_LAST) oam_act_d = 1'b0;
      end
      if (wr46) begin
         page_d    = cpu_di;
         idx_d     = 8'd0;
         oam_act_d = 1'b1;
      end

      if (vram_wr_c) begin
         hsrc_d = hsrc_q + 16'd1;
         dst_d  = dst_q + 13'd1;
         bcnt_d = bcnt_q + 16'd1;
         if (bcnt_q == BLK_LAST) begin
            bcnt_d   = 16'd0;
            blocks_d = blocks_q - 8'd1;
            if (state_q == GDMA) begin
               if (blocks_q == 8'd1) state_d = IDLE;
            end else if (cancel_pend_q) begin
               state_d     = IDLE;
               cancelled_d = 1'b1;
            end else if (blocks_q == 8'd1) begin
               state_d = IDLE;
            end else begin
               state_d = HWAIT;
            end
         end
      end

      if (state_q == HWAIT && (hblank_start || !lcd_on)) state_d = HBLOCK;

      if (wr_h) begin
         case (cpu_addr)
            8'h51: hsrc_d[15:8] = cpu_di;
            8'h52: hsrc_d[7:0]  = {cpu_di[7:4], 4'h0};
            8'h53: dst_d[12:8]  = cpu_di[4:0];
            8'h54: dst_d[7:0]   = {cpu_di[7:4], 4'h0};
            8'h55: begin
               if (state_q == IDLE) begin
                  blocks_d      = {1'b0, cpu_di[6:0]} + 8'd1;
                  bcnt_d        = 16'd0;
                  cancelled_d   = 1'b0;
                  cancel_pend_d = 1'b0;
                  state_d       = cpu_di[7] ? HWAIT : GDMA;
               end else if (!cpu_di[7]) begin
                  if (state_q == HWAIT) begin
                     state_d     = IDLE;
                     cancelled_d = 1'b1;
                  end else if (state_q == HBLOCK) begin
                     cancel_pend_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      want_h = (state_d == GDMA) || (state_d == HBLOCK);
      if (!busy_q || strobe || oam_restart) begin
         cyc_d = '0;
         if (want_h) begin
            busy_d  = 1'b1;
            owner_d = 1'b1;
         end else if (oam_act_d) begin
            busy_d  = 1'b1;
            owner_d = 1'b0;
         end else begin
            busy_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         busy_q        <= 1'b0;
         owner_q       <= 1'b0;
         hwr_q         <= 1'b0;
         cyc_q         <= '0;
         oam_act_q     <= 1'b0;
         page_q        <= 8'd0;
         idx_q         <= 8'd0;
         hsrc_q        <= 16'd0;
         dst_q         <= 13'd0;
         bcnt_q        <= 16'd0;
         blocks_q      <= 8'd0;
         cancelled_q   <= 1'b0;
         cancel_pend_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         busy_q        <= busy_d;
         owner_q       <= owner_d;
         hwr_q         <= vram_wr_c;
         cyc_q         <= cyc_d;
         oam_act_q     <= oam_act_d;
         page_q        <= page_d;
         idx_q         <= idx_d;
         hsrc_q        <= hsrc_d;
         dst_q         <= dst_d;
         bcnt_q        <= bcnt_d;
         blocks_q      <= blocks_d;
         cancelled_q   <= cancelled_d;
         cancel_pend_q <= cancel_pend_d;
      end
   end

   assign blk_m1 = blocks_q - 8'd1;

   always_comb begin
      cpu_do = 8'hFF;
      if (cpu_sel_reg) begin
         if (cpu_addr == 8'h46) cpu_do = page_q;
         else if (cpu_addr == 8'h55 && HAS_HDMA) begin
            if (state_q != IDLE)  cpu_do = {1'b0, blk_m1[6:0]};
            else if (cancelled_q) cpu_do = {1'b1, blk_m1[6:0]};
         end
      end
   end

   // Stall covers the HDMA slots plus the cycle after each VRAM write.
   assign cpu_stall      = (busy_q && owner_q) || hwr_q;
   assign src_rd         = busy_q;
   assign src_addr       = !busy_q ? 16'd0 : (owner_q ? hsrc_q : {page_q, idx_q});
   assign oam_dma_active = oam_act_q;
   assign oam_wr         = oam_wr_c;
   assign oam_addr       = idx_q;
   assign oam_di         = oam_wr_c ? src_data : 8'd0;
   assign vram_wr        = vram_wr_c;
   assign vram_addr      = dst_q;
   assign vram_di        = vram_wr_c ? src_data : 8'd0;
endmodule

// File: tb/tb_video_dma.sv
// Directed bench for video_dma: OAM DMA, GDMA, H-blank DMA, cancel, arbitration, wrap, reset abort.
module tb_video_dma;
   logic        clk = 1'b0, reset = 1'b1;
   logic        cpu_sel_reg = 1'b0, cpu_wr = 1'b0;
   logic [7:0]  cpu_addr = 8'd0, cpu_di = 8'd0, cpu_do;
   logic        lcd_on = 1'b1, hblank_start = 1'b0;
   logic        cpu_stall, src_rd, oam_dma_active, oam_wr, vram_wr;
   logic [15:0] src_addr;
   logic [7:0]  src_data, oam_addr, oam_di, vram_di;
   logic [12:0] vram_addr;

   always #5 clk = ~clk;
   assign src_data = src_addr[7:0] ^ 8'h5A;

   video_dma dut (
      .clk(clk), .reset(reset), .cpu_sel_reg(cpu_sel_reg), .cpu_addr(cpu_addr),
      .cpu_wr(cpu_wr), .cpu_di(cpu_di), .cpu_do(cpu_do), .lcd_on(lcd_on),
      .hblank_start(hblank_start), .cpu_stall(cpu_stall), .src_rd(src_rd),
      .src_addr(src_addr), .src_data(src_data), .oam_dma_active(oam_dma_active),
      .oam_wr(oam_wr), .oam_addr(oam_addr), .oam_di(oam_di), .vram_wr(vram_wr),
      .vram_addr(vram_addr), .vram_di(vram_di)
   );

   typedef struct {bit v; int addr; int src; int dat; int cyc;} ev_t;
   ev_t log_q[$];
   int  cyc_n = 0, act_cnt = 0, stall_cnt = 0, both_cnt = 0;

   always @(negedge clk) begin
      cyc_n <= cyc_n + 1;
      if (oam_dma_active) act_cnt <= act_cnt + 1;
      if (cpu_stall) stall_cnt <= stall_cnt + 1;
      if (oam_wr && vram_wr) both_cnt <= both_cnt + 1;
      if (oam_wr) log_q.push_back('{1'b0, int'(oam_addr), int'(src_addr), int'(oam_di), cyc_n});
      if (vram_wr) log_q.push_back('{1'b1, int'(vram_addr), int'(src_addr), int'(vram_di), cyc_n});
   end

   int n_cmp = 0, n_bad = 0;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
   endtask

   task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      cpu_sel_reg = 1'b1; cpu_addr = a; cpu_di = d; cpu_wr = 1'b1;
      @(posedge clk); #1;
      cpu_wr = 1'b0; cpu_sel_reg = 1'b0;
   endtask

   task automatic reg_rd(input logic [7:0] a, output logic [7:0] d);
      cpu_sel_reg = 1'b1; cpu_addr = a; #1;
      d = cpu_do;
      cpu_sel_reg = 1'b0;
   endtask

   task automatic hblank_pulse();
      @(posedge clk); #1; hblank_start = 1'b1;
      @(posedge clk); #1; hblank_start = 1'b0;
   endtask

   task automatic wait_quiet(input string tag, input int budget);
      int n = 0;
      while ((src_rd || oam_dma_active || cpu_stall) && n < budget) begin step(1); n++; end
      chk(tag, (n >= budget), 1'b0);
   endtask

   task automatic setup_hdma(input logic [7:0] s1, s2, d1, d2);
      reg_wr(8'h51, s1); reg_wr(8'h52, s2); reg_wr(8'h53, d1); reg_wr(8'h54, d2);
   endtask

   logic [7:0] rd;
   int b, a0, s0, bad, noam;

   initial begin
      step(3);
      reset = 1'b0;
      step(1);
      chk("rst_active", oam_dma_active, 1'b0);
      chk("rst_stall", cpu_stall, 1'b0);
      chk("rst_src_rd", src_rd, 1'b0);
      chk("rst_vram_addr", vram_addr, 13'd0);
      reg_rd(8'h55, rd); chk("rst_ff55", rd, 8'hFF);
      reg_rd(8'h46, rd); chk("rst_ff46", rd, 8'h00);

      // OAM DMA from page $C1
      b = log_q.size(); a0 = act_cnt;
      reg_wr(8'h46, 8'hC1);
      wait_quiet("oam_wait", 2000);
      chk("oam_cnt", log_q.size() - b, 160);
      chk("oam_first_addr", log_q[b].addr, 0);
      chk("oam_first_src", log_q[b].src, 16'hC100);
      chk("oam_first_dat", log_q[b].dat, 8'h5A);
      chk("oam_last_addr", log_q[b+159].addr, 159);
      chk("oam_last_dat", log_q[b+159].dat, 8'd159 ^ 8'h5A);
      bad = 0;
      for (int i = 1; i < 160; i++)
         if (log_q[b+i].cyc - log_q[b+i-1].cyc != 4 || log_q[b+i].addr != i || log_q[b+i].v) bad++;
      chk("oam_spacing", bad, 0);
      chk("oam_active_cycles", act_cnt - a0, 640);

      // General-purpose HDMA, 2 blocks
      setup_hdma(8'hC0, 8'h05, 8'h81, 8'h2F);
      b = log_q.size(); s0 = stall_cnt;
      reg_wr(8'h55, 8'h01);
      wait_quiet("gdma_wait", 500);
      chk("gdma_cnt", log_q.size() - b, 32);
      bad = 0;
      for (int i = 0; i < 32; i++)
         if (!log_q[b+i].v || log_q[b+i].addr != 16'h0120 + i || log_q[b+i].src != 16'hC000 + i
             || log_q[b+i].dat != ((i & 8'hFF) ^ 8'h5A)) bad++;
      chk("gdma_seq", bad, 0);
      chk("gdma_stall_cycles", stall_cnt - s0, 129);
      reg_rd(8'h55, rd); chk("gdma_ff55", rd, 8'hFF);

      // H-blank HDMA, 3 blocks
      setup_hdma(8'hC0, 8'h05, 8'h81, 8'h2F);
      b = log_q.size();
      reg_wr(8'h55, 8'h82);
      step(20);
      chk("hdma_wait_none", log_q.size() - b, 0);
      chk("hdma_wait_stall", cpu_stall, 1'b0);
      reg_rd(8'h55, rd); chk("hdma_ff55_0", rd, 8'h02);
      hblank_pulse(); wait_quiet("hdma_w1", 200);
      chk("hdma_blk1", log_q.size() - b, 16);
      reg_rd(8'h55, rd); chk("hdma_ff55_1", rd, 8'h01);
      hblank_pulse(); wait_quiet("hdma_w2", 200);
      chk("hdma_blk2", log_q.size() - b, 32);
      hblank_pulse(); wait_quiet("hdma_w3", 200);
      chk("hdma_blk3", log_q.size() - b, 48);
      chk("hdma_last_addr", log_q[b+47].addr, 13'h014F);
      reg_rd(8'h55, rd); chk("hdma_ff55_3", rd, 8'hFF);

      // Cancel in HWAIT
      b = log_q.size();
      reg_wr(8'h55, 8'h83);
      hblank_pulse(); wait_quiet("cancel_w1", 200);
      chk("cancel_blk1", log_q.size() - b, 16);
      reg_wr(8'h55, 8'h00);
      hblank_pulse(); step(30);
      chk("cancel_none", log_q.size() - b, 16);
      reg_rd(8'h55, rd); chk("cancel_ff55", rd, 8'h82);

      // GDMA preempting OAM DMA after 10 bytes
      setup_hdma(8'hD0, 8'h00, 8'h00, 8'h00);
      b = log_q.size();
      reg_wr(8'h46, 8'hC2);
      for (int n = 0; n < 200 && log_q.size() - b < 10; n++) step(1);
      chk("arb_ten", log_q.size() - b, 10);
      reg_wr(8'h55, 8'h00);
      wait_quiet("arb_wait", 3000);
      chk("arb_total", log_q.size() - b, 176);
      bad = 0; noam = 0;
      for (int i = 0; i <= 10; i++) if (log_q[b+i].v || log_q[b+i].addr != i) bad++;
      for (int i = 0; i < 16; i++)
         if (!log_q[b+11+i].v || log_q[b+11+i].src != 16'hD000 + i || log_q[b+11+i].addr != i) bad++;
      chk("arb_order", bad, 0);
      chk("arb_resume_idx", log_q[b+27].addr, 11);
      chk("arb_resume_v", log_q[b+27].v, 1'b0);
      for (int i = 0; i < 176; i++) if (!log_q[b+i].v) noam++;
      chk("arb_oam_total", noam, 160);

      // VRAM address wrap from $1FF0
      setup_hdma(8'hC0, 8'h00, 8'h9F, 8'hF0);
      b = log_q.size();
      reg_wr(8'h55, 8'h01);
      wait_quiet("wrap_wait", 500);
      chk("wrap_cnt", log_q.size() - b, 32);
      chk("wrap_hi", log_q[b+15].addr, 13'h1FFF);
      chk("wrap_lo", log_q[b+16].addr, 13'h0000);
      bad = 0;
      for (int i = 0; i < 32; i++) if (log_q[b+i].addr != ((16'h1FF0 + i) & 16'h1FFF)) bad++;
      chk("wrap_seq", bad, 0);
      chk("never_both", both_cnt, 0);

      // Reset during an OAM transfer
      reg_wr(8'h46, 8'hC3);
      step(50);
      reset = 1'b1;
      b = log_q.size();
      step(1);
      reset = 1'b0;
      chk("rst_mid_active", oam_dma_active, 1'b0);
      chk("rst_mid_src_rd", src_rd, 1'b0);
      step(40);
      chk("rst_mid_nowr", log_q.size() - b, 0);
      reg_rd(8'h46, rd); chk("rst_mid_ff46", rd, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/video_dma.md
Name: video_dma

Overview:
- Parametrised DMA engine, split out of the video block's built-in OAM copier.
- Provides DMG OAM DMA ($FF46) plus CGB VRAM DMA (HDMA, $FF51-$FF55) in general-purpose and H-blank modes.
- Sits beside the video block: reads from the shared source bus, writes to OAM and VRAM, stalls the CPU during VRAM copies.

Parameters:
- OAM_BYTES, 160, bytes per OAM DMA transfer.
- CYCLES_PER_BYTE, 4, clk cycles per transferred byte (any value >= 2).
- HDMA_BLOCK, 16, bytes per H-blank block; length unit for $FF55.
- CGB, 1, 0 disables HDMA: $FF51-$FF55 writes ignored, reads return 8'hFF.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_sel_reg  in  1  CPU access to $FF00-$FF7F register page
- cpu_addr  in  8  low address byte
- cpu_wr  in  1  write strobe, one cycle
- cpu_di  in  8  write data
- cpu_do  out  8  read data for $46, $51-$55; 8'hFF otherwise
- lcd_on  in  1  LCDC bit 7
- hblank_start  in  1  one-cycle pulse on PPU entry to mode 0
- cpu_stall  out  1  CPU halted while HDMA owns the bus
- src_rd  out  1  source read request
- src_addr  out  16  source address
- src_data  in  8  source data, valid by last cycle of a byte slot
- oam_dma_active  out  1  OAM DMA in progress (CPU limited to HRAM)
- oam_wr  out  1  OAM write pulse
- oam_addr  out  8  OAM byte index
- oam_di  out  8  OAM write data
- vram_wr  out  1  VRAM write pulse
- vram_addr  out  13  VRAM byte address
- vram_di  out  8  VRAM write data

Behaviour:
- Reset: all outputs 0 except cpu_do; $FF46=0; HDMA src/dst=0; HDMA state IDLE; $FF55 reads 8'hFF.
- Byte slot: CYCLES_PER_BYTE cycles. src_rd and src_addr are held for the whole slot. On the last cycle, the write strobe (oam_wr or vram_wr) pulses for one cycle with data = src_data.
- OAM DMA:
  - A write to $46 latches the page, sets oam_dma_active next cycle and starts at byte 0.
  - src_addr = {page, idx}; oam_addr = idx; idx runs 0..OAM_BYTES-1.
  - oam_dma_active clears on the cycle after the last oam_wr.
  - A rewrite of $46 while active restarts at idx 0 with the new page.
- HDMA registers:
  - $51/$52 give source; low 4 bits are forced to 0.
  - $53/$54 give destination; vram_addr = {$53[4:0], $54[7:4], 4'b0}.
  - All four are write-only; reads return 8'hFF.
- $55 write while HDMA is IDLE:
  - len = (di[6:0]+1) blocks of HDMA_BLOCK bytes.
  - di[7]=0 enters state GDMA; di[7]=1 enters state HWAIT.
- HDMA state machine IDLE / GDMA / HWAIT / HBLOCK:
  - GDMA: copies all len*HDMA_BLOCK bytes back to back, then goes to IDLE.
  - HWAIT: goes to HBLOCK on hblank_start; goes to HBLOCK immediately while lcd_on=0.
  - HBLOCK: copies exactly HDMA_BLOCK bytes, decrements remaining blocks, then goes to HWAIT, or to IDLE when remaining reaches 0.
  - hblank_start during HBLOCK or GDMA is ignored.
- Cancel and other $55 writes:
  - $55 write with di[7]=0 during HWAIT: go IDLE immediately; status marked cancelled.
  - Same write during HBLOCK: the current block completes, then go IDLE cancelled.
  - $55 write with di[7]=1 while active: ignored.
- $55 read:
  - Active: {1'b0, remaining_blocks-1}.
  - Completed: 8'hFF.
  - Cancelled: {1'b1, remaining_blocks-1}.
- Counters:
  - src_addr increments per byte with 16-bit wrap.
  - vram_addr increments per byte with 13-bit wrap ($1FFF -> $0000); the copy continues after the wrap.
  - HDMA src/dst registers advance with the transfer, so a new start continues from the current addresses.
- cpu_stall: high in GDMA and HBLOCK from the first slot cycle through the cycle after the last vram_wr; low otherwise.
- Arbitration:
  - HDMA has priority at byte-slot boundaries.
  - An in-flight OAM slot always completes; OAM DMA then freezes (oam_dma_active stays 1) until HDMA leaves GDMA/HBLOCK.
  - oam_wr and vram_wr never assert in the same cycle.
- Reset mid-transfer aborts everything within one cycle; no further write strobes.

Test Plan:
- Write $46=8'hC1 -> 160 oam_wr pulses, spaced 4 cycles apart. The first pulse has oam_addr=0, src_addr=$C100; the last has oam_addr=159. oam_dma_active is high for 640 cycles.
- Write $51=$C0, $52=$05, $53=$81, $54=$2F, $55=$01 -> 32 vram_wr pulses with vram_addr $0120..$013F and src $C000..$C01F. cpu_stall is high throughout; $55 then reads 8'hFF.
- Same setup with $55=$82, lcd_on=1 -> no writes until hblank_start. Each hblank_start yields 16 writes. After pulse 1, $55 reads 8'h01; after pulse 3, it reads 8'hFF.
- H-blank mode $55=$83, one block done, then write $55=$00 during HWAIT -> no further writes; $55 reads 8'h82.
- Start OAM DMA, then a GDMA of 1 block after 10 OAM bytes -> OAM pauses after byte 10's slot. 16 vram_wr pulses follow, then OAM resumes at idx 11. Total oam_wr count is 160.
- Destination $9FF0 with $55=$01 -> vram_addr goes $1FF0..$1FFF, then $0000..$000F.
